svm_sequencer: RTL and testbench

- Feeds three-phase voltage commands from an upstream producer into the svm PWM block, one command per PWM period.
- Buffers commands in a small FIFO. Drives the svm in_valid/ready handshake and keeps vA/vB/vC and periodTop stable for the whole svm capture window and period.
- Handles underrun by repeating the last command, and handles faults by killing the PWM stage.
- Sits between the modulation datapath and svm.

---
 rtl/svm_pkg.sv | 30 +++
 rtl/svm_cmd_fifo.sv | 53 +++++
 rtl/svm_sequencer.sv | 170 +++++++++++++++++
 tb/tb_svm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared types and constants for the svm command sequencer and its FIFO.
package svm_pkg;

    localparam int D_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        HOLD,
        WAIT,
        FAULT
    } state_t;

    typedef struct packed {
        logic [D_WIDTH-1:0] va;
        logic [D_WIDTH-1:0] vb;
        logic [D_WIDTH-1:0] vc;
    } cmd_t;

    localparam logic [D_WIDTH-1:0] NEUTRAL_V = '0;
    localparam logic [D_WIDTH-1:0] MIN_TOP   = D_WIDTH'(2);
    localparam cmd_t NEUTRAL_CMD = '{va: NEUTRAL_V, vb: NEUTRAL_V, vc: NEUTRAL_V};

    // The svm counter cannot run a period shorter than MIN_TOP.
    function automatic logic [D_WIDTH-1:0] clamp_top(input logic [D_WIDTH-1:0] top);
        return (top < MIN_TOP) ? MIN_TOP : top;
    endfunction

endpackage

// File: rtl/svm_cmd_fifo.sv
// Small synchronous FIFO of three-phase commands with a single-cycle flush.
module svm_cmd_fifo
    import svm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  cmd_t din,
    output logic full,
    output logic empty,
    output cmd_t head
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/svm_sequencer.sv
// Feeds one buffered three-phase command per PWM period into the svm block,
// repeating the last command on underrun and killing the PWM stage on fault.
module svm_sequencer
    import svm_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [D_WIDTH-1:0] s_vA,
    input  logic [D_WIDTH-1:0] s_vB,
    input  logic [D_WIDTH-1:0] s_vC,
    input  logic [D_WIDTH-1:0] cfg_top,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [D_WIDTH-1:0] m_vA,
    output logic [D_WIDTH-1:0] m_vB,
    output logic [D_WIDTH-1:0] m_vC,
    output logic [D_WIDTH-1:0] m_top,
    input  logic               fault_in,
    input  logic               fault_clr,
    output logic               pwm_kill,
    output logic               fault_active,
    output logic [15:0]        underrun_cnt,
    output logic [D_WIDTH-1:0] period_cnt
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [D_WIDTH-1:0] top_q, top_d;
    logic               valid_q, valid_d;
    logic               kill_q, kill_d;
    logic               fault_q, fault_d;
    logic               have_last_q, have_last_d;
    logic [15:0]        under_q, under_d;
    logic [D_WIDTH-1:0] period_q, period_d;
    logic [HW-1:0]      hold_q, hold_d;

    logic fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    cmd_t fifo_head;

    assign s_ready   = !fifo_full && (state_q != FAULT) && !rst;
    assign fifo_push = s_valid && s_ready;

    svm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   ('{va: s_vA, vb: s_vB, vc: s_vC}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        top_d       = top_q;
        valid_d     = valid_q;
        kill_d      = kill_q;
        fault_d     = fault_q;
        have_last_d = have_last_q;
        under_d     = under_q;
        period_d    = period_q;
        hold_d      = hold_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        if (fault_in) begin
            state_d     = FAULT;
            kill_d      = 1'b1;
            fault_d     = 1'b1;
            valid_d     = 1'b0;
            cmd_d       = NEUTRAL_CMD;
            have_last_d = 1'b0;
            fifo_flush  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (enable) state_d = LOAD;
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        cmd_d    = fifo_head;
                        fifo_pop = 1'b1;
                    end else begin
                        // Underrun: cmd_q already holds the last command if there was one.
                        if (!have_last_q) cmd_d = NEUTRAL_CMD;
                        if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
                    end
                    top_d       = clamp_top(cfg_top);
                    have_last_d = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = ISSUE;
                end
                ISSUE: begin
                    // The svm captured on the previous negedge and has already dropped ready.
                    if (valid_q && !m_ready) begin
                        valid_d  = 1'b0;
                        period_d = period_q + D_WIDTH'(1);
                        hold_d   = HW'(HOLD_CYCLES);
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    hold_d = hold_q - HW'(1);
                    if (hold_q <= HW'(1)) state_d = WAIT;
                end
                WAIT: begin
                    if (m_ready) state_d = enable ? LOAD : IDLE;
                end
                FAULT: begin
                    if (fault_clr) begin
                        kill_d  = 1'b0;
                        fault_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= NEUTRAL_CMD;
            top_q       <= MIN_TOP;
            valid_q     <= 1'b0;
            kill_q      <= 1'b0;
            fault_q     <= 1'b0;
            have_last_q <= 1'b0;
            under_q     <= '0;
            period_q    <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            top_q       <= top_d;
            valid_q     <= valid_d;
            kill_q      <= kill_d;
            fault_q     <= fault_d;
            have_last_q <= have_last_d;
            under_q     <= under_d;
            period_q    <= period_d;
            hold_q      <= hold_d;
        end
    end

    assign m_valid      = valid_q;
    assign m_vA         = cmd_q.va;
    assign m_vB         = cmd_q.vb;
    assign m_vC         = cmd_q.vc;
    assign m_top        = top_q;
    assign pwm_kill     = kill_q;
    assign fault_active = fault_q;
    assign underrun_cnt = under_q;
    assign period_cnt   = period_q;

endmodule

// File: tb/tb_svm_sequencer.sv
// Bench for svm_sequencer: an svm model captures each issued command on the
// negedge and a scoreboard compares it with the expected command queue.
module tb_svm_sequencer;

    localparam int PERIOD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_vA = '0, s_vB = '0, s_vC = '0, cfg_top = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_vA, m_vB, m_vC, m_top;
    logic        fault_in = 1'b0, fault_clr = 1'b0;
    logic        pwm_kill, fault_active;
    logic [15:0] underrun_cnt, period_cnt;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] top;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    exp_t cap;
    int   total = 0;
    int   bad = 0;
    int   cap_count = 0;
    int   busy = 0;

    svm_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_vA         (s_vA),
        .s_vB         (s_vB),
        .s_vC         (s_vC),
        .cfg_top      (cfg_top),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_vA         (m_vA),
        .m_vB         (m_vB),
        .m_vC         (m_vC),
        .m_top        (m_top),
        .fault_in     (fault_in),
        .fault_clr    (fault_clr),
        .pwm_kill     (pwm_kill),
        .fault_active (fault_active),
        .underrun_cnt (underrun_cnt),
        .period_cnt   (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // svm model and scoreboard monitor: capture on negedge, hold ready low for the period.
    always @(negedge clk) begin
        if (rst || pwm_kill) begin
            m_ready = 1'b1;
            busy    = 0;
        end else if (m_ready && m_valid) begin
            m_ready = 1'b0;
            busy    = PERIOD;
            cap     = '{m_vA, m_vB, m_vC, m_top};
            cap_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("issued_cmd", {m_vA, m_vB, m_vC, m_top}, {exp_e.a, exp_e.b, exp_e.c, exp_e.top});
            end
        end else if (!m_ready) begin
            check("frozen_in_period", {m_vA, m_vB, m_vC, m_top}, {cap.a, cap.b, cap.c, cap.top});
            if (busy == 0) m_ready = 1'b1;
            else busy--;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input logic [15:0] a, b, c, top);
        exp_q.push_back('{a, b, c, top});
    endtask

    task automatic push_cmd(input logic [15:0] a, b, c);
        int i = 0;
        while (!s_ready && i < 50) begin
            tick(1);
            i++;
        end
        if (!s_ready) begin
            check("push_timeout", 64'd0, 64'd1);
        end else begin
            s_valid = 1'b1;
            s_vA = a; s_vB = b; s_vC = c;
            tick(1);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_caps(input int target);
        for (int i = 0; i < 600 && cap_count < target; i++) tick(1);
        check("capture_count", 64'(cap_count), 64'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_v"}, {16'h0, m_vA, m_vB, m_vC}, 64'd0);
        check({tag, "_m_top"}, 64'(m_top), 64'd2);
        check({tag, "_kill_fault"}, {62'd0, pwm_kill, fault_active}, 64'd0);
        check({tag, "_counters"}, {32'd0, underrun_cnt, period_cnt}, 64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        check_reset_values("reset");
        rst = 1'b0;
        #1;
        check("s_ready_after_reset", 64'(s_ready), 64'd1);

        // Basic run followed by one underrun period
        cfg_top = 16'd100;
        push_cmd(16'h1000, 16'h2000, 16'h3000);
        expect_cmd(16'h1000, 16'h2000, 16'h3000, 16'd100);
        expect_cmd(16'h1000, 16'h2000, 16'h3000, 16'd100);
        enable = 1'b1;
        tick(1);
        check("m_valid_low_in_load", 64'(m_valid), 64'd0);
        tick(1);
        check("m_valid_two_after_enable", 64'(m_valid), 64'd1);
        wait_caps(1);
        check("basic_period_cnt", 64'(period_cnt), 64'd1);
        check("basic_underrun_cnt", 64'(underrun_cnt), 64'd0);
        wait_caps(2);
        enable = 1'b0;
        tick(PERIOD + 6);
        check("underrun_reissue_cnt", 64'(underrun_cnt), 64'd1);
        check("underrun_period_cnt", 64'(period_cnt), 64'd2);
        check("idle_m_valid", 64'(m_valid), 64'd0);

        // Underrun with nothing ever pushed: neutral vector
        do_reset();
        cfg_top = 16'd100;
        expect_cmd(16'h0, 16'h0, 16'h0, 16'd100);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_caps(3);
        tick(PERIOD + 6);
        check("neutral_underrun_cnt", 64'(underrun_cnt), 64'd1);
        check("neutral_period_cnt", 64'(period_cnt), 64'd1);

        // FIFO full: four commands accepted, a fifth refused, order kept
        do_reset();
        cfg_top = 16'd100;
        push_cmd(16'h0101, 16'h0102, 16'h0103);
        push_cmd(16'h0201, 16'h0202, 16'h0203);
        push_cmd(16'h0301, 16'h0302, 16'h0303);
        push_cmd(16'h0401, 16'h0402, 16'h0403);
        check("s_ready_low_when_full", 64'(s_ready), 64'd0);
        s_valid = 1'b1; s_vA = 16'h0501; s_vB = 16'h0502; s_vC = 16'h0503;
        tick(2);
        check("s_ready_still_low", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        expect_cmd(16'h0101, 16'h0102, 16'h0103, 16'd100);
        expect_cmd(16'h0201, 16'h0202, 16'h0203, 16'd100);
        expect_cmd(16'h0301, 16'h0302, 16'h0303, 16'd100);
        expect_cmd(16'h0401, 16'h0402, 16'h0403, 16'd100);
        expect_cmd(16'h0401, 16'h0402, 16'h0403, 16'd100);
        enable = 1'b1;
        wait_caps(8);
        enable = 1'b0;
        tick(PERIOD + 6);
        check("full_underrun_cnt", 64'(underrun_cnt), 64'd1);
        check("full_period_cnt", 64'(period_cnt), 64'd5);

        // Top change mid-period and clamp of zero top
        do_reset();
        cfg_top = 16'd100;
        push_cmd(16'h0AAA, 16'h0BBB, 16'h0CCC);
        expect_cmd(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'd100);
        expect_cmd(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'd50);
        expect_cmd(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'd2);
        enable = 1'b1;
        wait_caps(9);
        tick(4);
        cfg_top = 16'd50;
        tick(1);
        check("top_frozen_in_wait", 64'(m_top), 64'd100);
        wait_caps(10);
        tick(1);
        cfg_top = 16'd0;
        wait_caps(11);
        enable = 1'b0;
        tick(PERIOD + 6);
        check("top_clamped", 64'(m_top), 64'd2);
        check("top_underrun_cnt", 64'(underrun_cnt), 64'd2);

        // Fault during HOLD, clear blocked while fault_in is high
        do_reset();
        cfg_top = 16'd100;
        push_cmd(16'h1111, 16'h2222, 16'h3333);
        push_cmd(16'h4444, 16'h5555, 16'h6666);
        expect_cmd(16'h1111, 16'h2222, 16'h3333, 16'd100);
        enable = 1'b1;
        wait_caps(12);
        fault_in = 1'b1;
        enable = 1'b0;
        tick(1);
        fault_in = 1'b0;
        check("fault_kill_active", {62'd0, pwm_kill, fault_active}, 64'd3);
        check("fault_s_ready", 64'(s_ready), 64'd0);
        check("fault_outputs_zero", {15'd0, m_valid, m_vA, m_vB, m_vC}, 64'd0);
        fault_clr = 1'b1;
        fault_in = 1'b1;
        tick(2);
        check("fault_clr_blocked", {62'd0, pwm_kill, fault_active}, 64'd3);
        fault_in = 1'b0;
        tick(1);
        fault_clr = 1'b0;
        check("fault_cleared", {62'd0, pwm_kill, fault_active}, 64'd0);
        check("fault_cleared_s_ready", 64'(s_ready), 64'd1);
        expect_cmd(16'h0, 16'h0, 16'h0, 16'd100);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_caps(13);
        tick(PERIOD + 6);
        check("post_fault_underrun", 64'(underrun_cnt), 64'd1);
        check("post_fault_period", 64'(period_cnt), 64'd2);

        // Enable drop during ISSUE, then reset during HOLD
        do_reset();
        cfg_top = 16'd100;
        push_cmd(16'h0123, 16'h0456, 16'h0789);
        expect_cmd(16'h0123, 16'h0456, 16'h0789, 16'd100);
        enable = 1'b1;
        tick(2);
        check("issue_m_valid", 64'(m_valid), 64'd1);
        enable = 1'b0;
        wait_caps(14);
        tick(PERIOD + 6);
        check("enable_drop_period", 64'(period_cnt), 64'd1);
        check("enable_drop_idle", {m_valid, m_vA, m_vB, m_vC}, {1'b0, 16'h0123, 16'h0456, 16'h0789});
        push_cmd(16'h0F0F, 16'h0E0E, 16'h0D0D);
        expect_cmd(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'd100);
        enable = 1'b1;
        wait_caps(15);
        rst = 1'b1;
        enable = 1'b0;
        tick(1);
        check_reset_values("mid_reset");
        rst = 1'b0;
        tick(2);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
